// File: rtl/alu_wb_stage_pkg.sv
// alu_wb_stage_pkg: shared op encodings, flag bit positions and buffer depth
// for the ALU writeback stage and its flag generator.
package alu_wb_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_XOR = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] WB_DEPTH = 2'd2;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational NZCV flag generation for one ALU result.
// Optional macro ALU_OVERFLOW_EN enables the signed-overflow (V) flag; when it
// is undefined V is tied to 0 and the operands are not used.
module alu_flag_gen
    import alu_wb_stage_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   alu_control,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout,
    output logic [3:0]   flags
);

    logic overflow;

`ifdef ALU_OVERFLOW_EN
    // Signed overflow derived from operand and result sign bits; logic ops never overflow
    always_comb begin
        overflow = 1'b0;
        case (alu_control)
            ALU_ADD: overflow = (a[N-1] == b[N-1]) && (alu_out[N-1] != a[N-1]);
            ALU_SUB: overflow = (a[N-1] != b[N-1]) && (alu_out[N-1] != a[N-1]);
            default: overflow = 1'b0;
        endcase
    end
`else
    logic unusedOperands;
    assign unusedOperands = ^{a, b};
    assign overflow = 1'b0;
`endif

    // Assemble {N,Z,C,V}; carry only has meaning for the adder ops
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = alu_out[N-1];
        flags[FLAG_Z] = (alu_out == '0);
        flags[FLAG_C] = ((alu_control == ALU_ADD) || (alu_control == ALU_SUB)) ? alu_cout : 1'b0;
        flags[FLAG_V] = overflow;
    end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: two-entry skid buffer between the ALU and the register file.
// Each entry holds {result, rd, flags}; flags are computed as the entry is
// pushed. The architectural flag register takes the flags of each popped entry.
// Optional macro ALU_OVERFLOW_EN (see alu_flag_gen) enables the V flag.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   alu_control,
    input  logic [N-1:0] alu_out,
    input  logic         alu_cout,
    input  logic [2:0]   rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [2:0]   out_rd,
    output logic [3:0]   out_flags,
    output logic [3:0]   flags
);

    logic [N-1:0] resultMem_q [WB_DEPTH];
    logic [2:0]   rdMem_q     [WB_DEPTH];
    logic [3:0]   flagsMem_q  [WB_DEPTH];

    logic [1:0] count_q, count_d;
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;
    logic [3:0] flags_q;

    logic [3:0] newFlags;
    logic       pushEn;
    logic       popEn;

    alu_flag_gen #(.N(N)) flagGen (
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .flags       (newFlags)
    );

    // Handshake status comes only from registered occupancy, so out_ready never reaches in_ready
    assign in_ready   = (count_q < WB_DEPTH);
    assign out_valid  = (count_q != 2'd0);
    assign out_result = resultMem_q[rdPtr_q];
    assign out_rd     = rdMem_q[rdPtr_q];
    assign out_flags  = flagsMem_q[rdPtr_q];
    assign flags      = flags_q;
    assign pushEn     = in_valid && in_ready;
    assign popEn      = out_valid && out_ready;

    // Next occupancy and pointers; 1-bit pointers wrap naturally over the two slots
    always_comb begin
        count_d = count_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and flag register; reset wipes entries so outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            flags_q     <= 4'd0;
            resultMem_q <= '{default: '0};
            rdMem_q     <= '{default: '0};
            flagsMem_q  <= '{default: '0};
        end else begin
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (pushEn) begin
                resultMem_q[wrPtr_q] <= alu_out;
                rdMem_q[wrPtr_q]     <= rd;
                flagsMem_q[wrPtr_q]  <= newFlags;
            end
            if (popEn) begin
                flags_q <= flagsMem_q[rdPtr_q];
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed scenarios followed by randomized traffic, all
// compared against a queue-based reference model of the writeback buffer.
module tb_alu_wb_stage;

    localparam int W    = 4;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = 1 << W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   alu_control;
    logic [W-1:0] alu_out;
    logic         alu_cout;
    logic [2:0]   rd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_rd;
    logic [3:0]   out_flags;
    logic [3:0]   flags;

    typedef struct {
        int         res;
        int         rdv;
        logic [3:0] fl;
    } entry_t;

    entry_t     modelQ[$];
    logic [3:0] modelFlags;
    bit         modelClean;

    int testCount;
    int failCount;

    alu_wb_stage #(.N(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .rd          (rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_flags   (out_flags),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toSigned(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Reference flags from arithmetic meaning: V is true signed overflow of the real operation
    function automatic logic [3:0] refFlags(input int op, input int ua, input int ub,
                                            input int res, input bit cout);
        int  wide;
        bit  v;
        v = 1'b0;
`ifdef ALU_OVERFLOW_EN
        if (op == 0) begin
            wide = toSigned(ua) + toSigned(ub);
            v = (wide >= HALF) || (wide < -HALF);
        end else if (op == 1) begin
            wide = toSigned(ua) - toSigned(ub);
            v = (wide >= HALF) || (wide < -HALF);
        end
`else
        wide = 0;
`endif
        return {res >= HALF, res == 0, (op <= 1) ? cout : 1'b0, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive inputs, compare against model at negedge, then advance the model
    task automatic applyStimulus(input bit r, input bit v, input int op, input int ua,
                                 input int ub, input bit ordy, input int rdv);
        int     res;
        bit     cout;
        bit     doPush;
        bit     doPop;
        entry_t e;
        case (op)
            0:       begin res = (ua + ub) % FULL; cout = (ua + ub) >= FULL; end
            1:       begin res = (ua - ub + FULL) % FULL; cout = (ua >= ub); end
            2:       begin res = ua ^ ub; cout = 1'b1; end
            default: begin res = (FULL - 1) - ua; cout = 1'b1; end
        endcase
        rst         = r;
        in_valid    = v;
        alu_control = op[1:0];
        a           = ua[W-1:0];
        b           = ub[W-1:0];
        alu_out     = res[W-1:0];
        alu_cout    = cout;
        rd          = rdv[2:0];
        out_ready   = ordy;
        @(negedge clk);
        checkOutput("in_ready", in_ready, modelQ.size() < 2);
        checkOutput("out_valid", out_valid, modelQ.size() > 0);
        if (modelQ.size() > 0) begin
            checkOutput("out_result", out_result, modelQ[0].res);
            checkOutput("out_rd", out_rd, modelQ[0].rdv);
            checkOutput("out_flags", out_flags, modelQ[0].fl);
        end else if (modelClean) begin
            checkOutput("rst_result", out_result, 0);
            checkOutput("rst_rd", out_rd, 0);
            checkOutput("rst_out_flags", out_flags, 0);
        end
        checkOutput("flags", flags, modelFlags);
        if (r) begin
            modelQ.delete();
            modelFlags = 4'd0;
            modelClean = 1'b1;
        end else begin
            doPush = v && (modelQ.size() < 2);
            doPop  = ordy && (modelQ.size() > 0);
            if (doPop) begin
                modelFlags = modelQ[0].fl;
                void'(modelQ.pop_front());
            end
            if (doPush) begin
                e.res = res;
                e.rdv = rdv;
                e.fl  = refFlags(op, ua, ub, res, cout);
                modelQ.push_back(e);
                modelClean = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        testCount  = 0;
        failCount  = 0;
        modelFlags = 4'd0;
        modelClean = 1'b1;
        rst = 1'b1; in_valid = 1'b0; alu_control = 2'b00; a = '0; b = '0;
        alu_out = '0; alu_cout = 1'b0; rd = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // ADD 7+1 -> result 8, flags N..V (V only with overflow enabled)
        applyStimulus(0, 1, 0, 7, 1, 1, 2);
        checkOutput("add_result", out_result, 8);
        checkOutput("add_rd", out_rd, 2);
`ifdef ALU_OVERFLOW_EN
        checkOutput("add_flags", out_flags, 4'b1001);
`else
        checkOutput("add_flags_nov", out_flags, 4'b1000);
`endif
        // SUB 5-5 pops the ADD entry and becomes head
        applyStimulus(0, 1, 1, 5, 5, 1, 1);
        checkOutput("sub_flags", out_flags, 4'b0110);
        // XOR F^0 with carry in ignored
        applyStimulus(0, 1, 2, 15, 0, 1, 3);
        checkOutput("xor_flags", out_flags, 4'b1000);
        checkOutput("flags_after_sub_pop", flags, 4'b0110);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Backpressure: three pushes with out_ready low, third is dropped
        applyStimulus(0, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 2, 0, 0, 2);
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(0, 1, 0, 3, 0, 0, 3);
        checkOutput("full_head", out_result, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("drain_second", out_result, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("drain_empty", out_valid, 0);

        // Fill two entries with flags register at 0110, then reset
        applyStimulus(0, 1, 1, 5, 5, 0, 4);
        applyStimulus(0, 1, 0, 1, 1, 1, 5);
        applyStimulus(0, 1, 0, 2, 1, 0, 6);
        checkOutput("pre_rst_flags", flags, 4'b0110);
        applyStimulus(1, 1, 0, 3, 3, 1, 7);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_flags", flags, 4'b0000);

        // Occupancy 1 with simultaneous push and pop
        applyStimulus(0, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 4, 0, 1, 2);
        checkOutput("pushpop_head", out_result, 4);
        checkOutput("pushpop_in_ready", in_ready, 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, ($urandom % 4) != 0,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, FULL - 1)),
                          int'($urandom_range(0, FULL - 1)), ($urandom % 3) != 0,
                          int'($urandom_range(0, 7)));
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
